ula_multiciclo: RTL and testbench
=================================

// Module: ula_multiciclo
// PURPOSE
//  Parametrised, registered ALU for the V2 datapath: the successor to the 16-bit combinational ULA.
//  Keeps op codes 0-3 (add/sub/nand/pass) and adds shifts, an iterative multiply, status flags and valid/ready handshakes.
//  Sits between the register-file read port and the writeback mux; the control FSM issues ops and stalls on in_ready.
// PARAMETERS
//  WIDTH   16  datapath width in bits, >= 4
//  OP_W    3   op_select width (fixed encoding below)
// PORTS
//  clock      in   1      single clock, all state on rising edge
//  resetn     in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block accepts an operation this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B (also shift amount)
//  op_select  in   OP_W   0 add, 1 sub, 2 nand, 3 pass A, 4 shl, 5 shr, 6 mul, 7 pass A
//  out_valid  out  1      r/flags hold a result
//  out_ready  in   1      consumer takes result
//  r          out  WIDTH  result
//  flag_z     out  1      r == 0
//  flag_n     out  1      r[WIDTH-1]
//  flag_c     out  1      carry / borrow / mul high-half nonzero
//  flag_v     out  1      signed overflow (add/sub only)
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE, in_ready=1, out_valid=0, r=0, all flags 0, internal regs 0.
//  Accept = in_valid & in_ready; A, B, op captured on that edge; inputs ignored otherwise.
//  FSM states: IDLE, MUL, DONE.
//   IDLE: on accept of ops 0-5,7 -> compute, load r/flags, go DONE (out_valid=1 the next cycle, latency 1).
//         on accept of op 6 -> load a_acc={0,A} (2*WIDTH), b_sh=B, prod=0, cnt=0; go MUL.
//   MUL:  each cycle: if b_sh[0], prod+=a_acc; a_acc<<=1; b_sh>>=1; cnt++.
//         after exactly WIDTH iterations load r=prod[WIDTH-1:0], go DONE. No early exit.
//         Latency accept -> out_valid = WIDTH+1 cycles. in_ready=0 throughout.
//   DONE: out_valid=1; r and flags stable until out_ready=1.
//         out_ready=1 & no accept -> IDLE, out_valid=0 next cycle.
//         in_ready = (state==IDLE) | (state==DONE & out_ready): same-cycle drain+accept allowed,
//         so single-cycle ops sustain 1 op/cycle with out_ready held high.
//  Arithmetic (all modulo 2^WIDTH, unsigned operands):
//   add: r=A+B, c=carry-out, v=(A[msb]==B[msb]) & (r[msb]!=A[msb]).
//   sub: r=A-B, c=borrow (1 iff A<B unsigned), v=(A[msb]!=B[msb]) & (r[msb]!=A[msb]).
//   nand: r=~(A&B). pass (3,7): r=A. For these c=0, v=0.
//   shl/shr: logical, amount = B; if B >= WIDTH, r=0. c = last bit shifted out (0 if B==0 or B>WIDTH). v=0.
//   mul: low WIDTH bits of A*B; c=1 iff prod[2*WIDTH-1:WIDTH] != 0; v=0.
//   z and n derive from the r value being loaded, for every op.
//  Boundaries:
//   out_ready low in DONE: holds indefinitely; no new accept.
//   in_valid during MUL: ignored (in_ready=0); the op is not queued.
//   resetn low mid-MUL or in DONE: operation discarded, no out_valid pulse afterwards.
//   op 6 with A=0 or B=0: still WIDTH+1 latency, r=0, z=1.
// STRUCTURE
//  Package ula_pkg: localparams OP_ADD..OP_PASS2 (3'd0..3'd7), state encoding ST_IDLE/ST_MUL/ST_DONE,
//  function computing flag_v for add/sub.
//  Sub-module ula_comb (combinational, WIDTH param): ops 0-5,7 -> r, c, v; the top holds FSM, multiply
//  iteration registers and output registers.
// TESTING
//  1 Reset: resetn=0 mid-cycle -> r=0, flags=0, out_valid=0, in_ready=1 immediately (async).
//  2 WIDTH=16 add 16'h7FFF+16'h0001 -> r=16'h8000, n=1, v=1, c=0, out_valid 1 cycle after accept.
//  3 sub 16'h0003-16'h0005 -> r=16'hFFFE, c=1, n=1; sub 16'h1234-16'h1234 -> r=0, z=1.
//  4 mul 16'h0100*16'h0100 -> r=0, z=1, c=1, out_valid exactly 17 cycles after accept; in_valid pulses in MUL ignored.
//  5 Back-to-back nand/shl/shr with out_ready=1: one result per cycle; shl 16'h8001 by 1 -> r=16'h0002, c=1;
//    shr by 16 -> r=0, c=0.
//  6 out_ready held 0 for 5 cycles in DONE -> r stable, in_ready=0; resetn pulse during MUL -> no out_valid.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the multicycle ALU: op encodings, FSM states and
// the signed-overflow rule shared by add and sub.
package ula_pkg;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_NAND  = 3'd2;
   localparam logic [2:0] OP_PASS  = 3'd3;
   localparam logic [2:0] OP_SHL   = 3'd4;
   localparam logic [2:0] OP_SHR   = 3'd5;
   localparam logic [2:0] OP_MUL   = 3'd6;
   localparam logic [2:0] OP_PASS2 = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Sub overflows when operand signs differ; add when they match. Either way r's sign left A's.
   function automatic logic calc_v(input logic is_sub, input logic a_msb,
                                   input logic b_msb, input logic r_msb);
      logic same_sign;
      same_sign = (a_msb == b_msb);
      return (is_sub ? !same_sign : same_sign) & (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/ula_comb.sv
// Single-cycle ALU ops (everything except multiply): result, carry/borrow
// and signed overflow.
module ula_comb
   import ula_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] r,
   output logic             c,
   output logic             v
);

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     dif;
   logic [2*WIDTH-1:0] shl_t;
   logic [2*WIDTH-1:0] shr_t;

   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};

   // Shifting in a double-width window leaves the last bit shifted out just past
   // the result half; it is zero for a shift of 0 or of more than WIDTH.
   assign shl_t = {{WIDTH{1'b0}}, a} << b;
   assign shr_t = {a, {WIDTH{1'b0}}} >> b;

   always_comb begin
      r = a;
      c = 1'b0;
      v = 1'b0;
      case (op)
         OP_ADD: begin
            r = sum[WIDTH-1:0];
            c = sum[WIDTH];
            v = calc_v(1'b0, a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
         end
         OP_SUB: begin
            r = dif[WIDTH-1:0];
            c = dif[WIDTH];
            v = calc_v(1'b1, a[WIDTH-1], b[WIDTH-1], dif[WIDTH-1]);
         end
         OP_NAND: r = ~(a & b);
         OP_SHL: begin
            r = shl_t[WIDTH-1:0];
            c = shl_t[WIDTH];
         end
         OP_SHR: begin
            r = shr_t[2*WIDTH-1:WIDTH];
            c = shr_t[WIDTH-1];
         end
         default: r = a;
      endcase
   end

endmodule

// File: rtl/ula_multiciclo.sv
// Registered ALU with valid/ready handshakes; single-cycle ops finish in one
// cycle, multiply iterates shift-and-add over WIDTH cycles.
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OP_W  = 3
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  op_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int CW = $clog2(WIDTH);

   state_t             state, state_nx;
   logic [2:0]         op;
   logic               accept;
   logic               is_mul;
   logic               last;
   logic [2*WIDTH-1:0] a_acc;
   logic [WIDTH-1:0]   b_sh;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_nx;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   c_r;
   logic               c_c;
   logic               c_v;

   assign op      = 3'(op_select);
   assign accept  = in_valid & in_ready;
   assign is_mul  = (op == OP_MUL);
   assign last    = (cnt == CW'(WIDTH - 1));
   assign prod_nx = b_sh[0] ? prod + a_acc : prod;

   ula_comb #(.WIDTH(WIDTH)) u_comb (
      .a  (A),
      .b  (B),
      .op (op),
      .r  (c_r),
      .c  (c_c),
      .v  (c_v)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept) state_nx = is_mul ? ST_MUL : ST_DONE;
         ST_MUL:  if (last)   state_nx = ST_DONE;
         ST_DONE: begin
            if (accept)         state_nx = is_mul ? ST_MUL : ST_DONE;
            else if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Draining and accepting in the same cycle keeps single-cycle ops at full rate.
   always_comb begin
      in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
      out_valid = (state == ST_DONE);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a_acc  <= '0;
         b_sh   <= '0;
         prod   <= '0;
         cnt    <= '0;
         r      <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else if (accept) begin
         if (is_mul) begin
            a_acc <= {{WIDTH{1'b0}}, A};
            b_sh  <= B;
            prod  <= '0;
            cnt   <= '0;
         end else begin
            r      <= c_r;
            flag_z <= (c_r == '0);
            flag_n <= c_r[WIDTH-1];
            flag_c <= c_c;
            flag_v <= c_v;
         end
      end else if (state == ST_MUL) begin
         prod  <= prod_nx;
         a_acc <= a_acc << 1;
         b_sh  <= b_sh >> 1;
         cnt   <= cnt + CW'(1);
         // Result is taken from the final iteration's sum so latency stays WIDTH+1.
         if (last) begin
            r      <= prod_nx[WIDTH-1:0];
            flag_z <= (prod_nx[WIDTH-1:0] == '0);
            flag_n <= prod_nx[WIDTH-1];
            flag_c <= |prod_nx[2*WIDTH-1:WIDTH];
            flag_v <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed test of ula_multiciclo (WIDTH=16): handshake timing, arithmetic,
// shift boundaries, iterative multiply and reset behaviour.
module tb_ula_multiciclo;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        c;
      logic        v;
   } vec_t;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [2:0]  op_select = '0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] r;
   logic        flag_z, flag_n, flag_c, flag_v;
   logic [3:0]  flags;

   int errors = 0;
   int checks = 0;

   assign flags = {flag_z, flag_n, flag_c, flag_v};

   always #5 clock = ~clock;

   ula_multiciclo #(.WIDTH(16), .OP_W(3)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op_select (op_select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
   );

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({out_valid, in_ready} !== 2'b01 || r !== 16'h0 || flags !== 4'b0) begin
         errors++;
         $display("FAIL reset_init: vld=%b rdy=%b r=%h flags=%b, want 0 1 0000 0000", out_valid, in_ready, r, flags);
      end
      resetn = 1'b1;
      @(negedge clock);
      A = 16'h8000; B = 16'h0; op_select = 3'd3; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clock); #1 in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || r !== 16'h8000 || flags !== 4'b0100) begin
         errors++;
         $display("FAIL reset_setup: vld=%b r=%h flags=%b, want 1 8000 0100", out_valid, r, flags);
      end
      @(negedge clock); #2 resetn = 1'b0; #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01 || r !== 16'h0 || flags !== 4'b0) begin
         errors++;
         $display("FAIL reset_async: vld=%b rdy=%b r=%h flags=%b, want 0 1 0000 0000", out_valid, in_ready, r, flags);
      end
      @(negedge clock); resetn = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_add();
      A = 16'h7FFF; B = 16'h0001; op_select = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL add_in_ready: got %b want 1", in_ready);
      end
      @(posedge clock); #1 in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || r !== 16'h8000) begin
         errors++;
         $display("FAIL add_result: vld=%b r=%h, want 1 8000", out_valid, r);
      end
      checks++;
      if (flags !== 4'b0101) begin
         errors++;
         $display("FAIL add_flags: zncv=%b want 0101", flags);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_drain: vld=%b want 0", out_valid);
      end
      out_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_sub();
      vec_t vt[2];
      logic [3:0] ef;
      vt[0] = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
      vt[1] = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         A = vt[i].a; B = vt[i].b; op_select = vt[i].op; in_valid = 1'b1; out_ready = 1'b0;
         @(posedge clock); #1 in_valid = 1'b0;
         ef = {vt[i].r == 16'h0, vt[i].r[15], vt[i].c, vt[i].v};
         checks++;
         if (out_valid !== 1'b1 || r !== vt[i].r) begin
            errors++;
            $display("FAIL sub_result[%0d]: vld=%b r=%h, want 1 %h", i, out_valid, r, vt[i].r);
         end
         checks++;
         if (flags !== ef) begin
            errors++;
            $display("FAIL sub_flags[%0d]: zncv=%b want %b", i, flags, ef);
         end
         out_ready = 1'b1;
         @(posedge clock); #1 out_ready = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic test_mul();
      vec_t vt[4];
      logic [3:0] ef;
      logic lat_ok;
      vt[0] = '{3'd6, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0};
      vt[1] = '{3'd6, 16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b0};
      vt[2] = '{3'd6, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0};
      vt[3] = '{3'd6, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         A = vt[i].a; B = vt[i].b; op_select = vt[i].op; in_valid = 1'b1; out_ready = 1'b0;
         @(posedge clock); #1 in_valid = 1'b0;
         lat_ok = (out_valid === 1'b0);
         for (int n = 2; n <= 17; n++) begin
            @(posedge clock); #1;
            if (n == 5) begin
               A = 16'h0001; B = 16'h0001; op_select = 3'd0; in_valid = 1'b1;
               checks++;
               if (in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL mul_busy_ready[%0d]: got %b want 0", i, in_ready);
               end
            end
            if (n == 8) in_valid = 1'b0;
            if (n < 17 && out_valid !== 1'b0) lat_ok = 1'b0;
         end
         checks++;
         if (out_valid !== 1'b1 || !lat_ok) begin
            errors++;
            $display("FAIL mul_latency[%0d]: vld=%b early=%b, want vld 1 exactly at cycle 17", i, out_valid, !lat_ok);
         end
         ef = {vt[i].r == 16'h0, vt[i].r[15], vt[i].c, 1'b0};
         checks++;
         if (r !== vt[i].r) begin
            errors++;
            $display("FAIL mul_result[%0d]: r=%h want %h", i, r, vt[i].r);
         end
         checks++;
         if (flags !== ef) begin
            errors++;
            $display("FAIL mul_flags[%0d]: zncv=%b want %b", i, flags, ef);
         end
         out_ready = 1'b1;
         @(posedge clock); #1;
         @(posedge clock); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_no_queue[%0d]: vld=%b want 0", i, out_valid);
         end
         out_ready = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic test_back_to_back();
      vec_t vt[11];
      logic [3:0] ef;
      vt[0]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0};
      vt[1]  = '{3'd4, 16'h8001, 16'd1,    16'h0002, 1'b1, 1'b0};
      vt[2]  = '{3'd5, 16'h0001, 16'd16,   16'h0000, 1'b0, 1'b0};
      vt[3]  = '{3'd4, 16'h0003, 16'd16,   16'h0000, 1'b1, 1'b0};
      vt[4]  = '{3'd5, 16'h8000, 16'd15,   16'h0001, 1'b0, 1'b0};
      vt[5]  = '{3'd5, 16'h0003, 16'd1,    16'h0001, 1'b1, 1'b0};
      vt[6]  = '{3'd4, 16'hFFFF, 16'd17,   16'h0000, 1'b0, 1'b0};
      vt[7]  = '{3'd7, 16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b0};
      vt[8]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      vt[9]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
      vt[10] = '{3'd4, 16'h1234, 16'd0,    16'h1234, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         A = vt[i].a; B = vt[i].b; op_select = vt[i].op; in_valid = 1'b1;
         @(posedge clock); #1;
         ef = {vt[i].r == 16'h0, vt[i].r[15], vt[i].c, vt[i].v};
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handshake[%0d]: vld=%b rdy=%b, want 1 1", i, out_valid, in_ready);
         end
         checks++;
         if (r !== vt[i].r) begin
            errors++;
            $display("FAIL b2b_result[%0d]: r=%h want %h", i, r, vt[i].r);
         end
         checks++;
         if (flags !== ef) begin
            errors++;
            $display("FAIL b2b_flags[%0d]: zncv=%b want %b", i, flags, ef);
         end
      end
      in_valid = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: vld=%b want 0", out_valid);
      end
      out_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_hold();
      A = 16'h0001; B = 16'h0002; op_select = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clock); #1;
      A = 16'h0005; B = 16'h0005;
      for (int k = 0; k < 5; k++) begin
         @(posedge clock); #1;
         checks++;
         if (out_valid !== 1'b1 || r !== 16'h0003 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: vld=%b r=%h rdy=%b, want 1 0003 0", k, out_valid, r, in_ready);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0 || r !== 16'h0003) begin
         errors++;
         $display("FAIL hold_release: vld=%b r=%h, want 0 0003", out_valid, r);
      end
      out_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_mul();
      logic seen;
      A = 16'h0003; B = 16'h0003; op_select = 3'd6; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clock); #1 in_valid = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock); resetn = 1'b0; #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01 || r !== 16'h0) begin
         errors++;
         $display("FAIL mid_mul_reset: vld=%b rdy=%b r=%h, want 0 1 0000", out_valid, in_ready, r);
      end
      @(negedge clock); resetn = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clock); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL mid_mul_no_result: out_valid pulse seen=%b want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_back_to_back();
      test_hold();
      test_reset_mid_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
